// File: rtl/set_assoc_cache.sv
`default_nettype none
// ============================================================================
// Module   : set_assoc_cache
// Brief    : N-way set-associative write-back, write-allocate cache with
//            lowest-invalid / per-set round-robin replacement.
// Revision : 1.0 - initial release
// ============================================================================
module set_assoc_cache #(
    parameter int ADDR_WIDTH      = 32,
    parameter int WORD_SIZE       = 32,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int NUM_SETS        = 64,
    parameter int WAYS            = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  cpu_req_valid,
    output logic                                  cpu_req_ready,
    input  logic                                  cpu_req_we,
    input  logic [ADDR_WIDTH-1:0]                 cpu_req_addr,
    input  logic [WORD_SIZE-1:0]                  cpu_req_wdata,
    output logic                                  cpu_resp_valid,
    output logic [WORD_SIZE-1:0]                  cpu_resp_rdata,
    output logic                                  mem_req_valid,
    input  logic                                  mem_req_ready,
    output logic                                  mem_req_we,
    output logic [ADDR_WIDTH-1:0]                 mem_req_addr,
    output logic [WORDS_PER_BLOCK*WORD_SIZE-1:0]  mem_req_wdata,
    input  logic                                  mem_resp_valid,
    input  logic [WORDS_PER_BLOCK*WORD_SIZE-1:0]  mem_resp_rdata
);

    localparam int OFFSET_WIDTH = $clog2(WORDS_PER_BLOCK);
    localparam int INDEX_WIDTH  = $clog2(NUM_SETS);
    localparam int TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
    localparam int BLOCK_SIZE   = WORDS_PER_BLOCK * WORD_SIZE;
    // Way numbers need at least one bit even when the cache is direct-mapped
    localparam int WAY_W        = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOOKUP    = 3'd1,
        S_WB_REQ    = 3'd2,
        S_FILL_REQ  = 3'd3,
        S_FILL_WAIT = 3'd4,
        S_RESPOND   = 3'd5
    } state_t;

    state_t                  r_state;
    logic                    r_req_we;
    logic [ADDR_WIDTH-1:0]   r_req_addr;
    logic [WORD_SIZE-1:0]    r_req_wdata;
    logic [WAY_W-1:0]        r_victim;
    logic                    r_resp_valid;
    logic [WORD_SIZE-1:0]    r_resp_rdata;
    logic                    r_mem_valid;
    logic                    r_mem_we;
    logic [ADDR_WIDTH-1:0]   r_mem_addr;
    logic [BLOCK_SIZE-1:0]   r_mem_wdata;

    logic [WAYS-1:0]         r_valid [NUM_SETS];
    logic [WAYS-1:0]         r_dirty [NUM_SETS];
    logic [WAY_W-1:0]        r_rr    [NUM_SETS];
    logic [TAG_WIDTH-1:0]    r_tag   [WAYS][NUM_SETS];
    logic [BLOCK_SIZE-1:0]   r_data  [WAYS][NUM_SETS];

    logic [TAG_WIDTH-1:0]    w_tag;
    logic [INDEX_WIDTH-1:0]  w_index;
    logic [OFFSET_WIDTH-1:0] w_offset;
    logic [WAYS-1:0]         w_hit_vec;
    logic                    w_hit;
    logic [WAY_W-1:0]        w_hit_way;
    logic [WAY_W-1:0]        w_victim;
    logic [WORD_SIZE-1:0]    w_hit_word;
    logic [BLOCK_SIZE-1:0]   w_fill_block;
    logic                    w_do_write_hit;
    logic                    w_do_fill;

    assign w_tag    = r_req_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign w_index  = r_req_addr[OFFSET_WIDTH +: INDEX_WIDTH];
    assign w_offset = r_req_addr[OFFSET_WIDTH-1:0];

    generate
        for (genvar g = 0; g < WAYS; g++) begin : g_way
            assign w_hit_vec[g] = r_valid[w_index][g] && (r_tag[g][w_index] == w_tag);
        end
    endgenerate

    assign w_hit = |w_hit_vec;

    // Descending scan so the lowest-numbered matching way wins
    always_comb begin
        w_hit_way = '0;
        w_victim  = r_rr[w_index];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (w_hit_vec[w]) w_hit_way = WAY_W'(w);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w_index][w]) w_victim = WAY_W'(w);
        end
    end

    assign w_hit_word = r_data[w_hit_way][w_index][w_offset*WORD_SIZE +: WORD_SIZE];

    always_comb begin
        w_fill_block = mem_resp_rdata;
        if (r_req_we) w_fill_block[w_offset*WORD_SIZE +: WORD_SIZE] = r_req_wdata;
    end

    assign w_do_write_hit = (r_state == S_LOOKUP) && w_hit && r_req_we;
    assign w_do_fill      = (r_state == S_FILL_WAIT) && mem_resp_valid;

    // Tag and data storage carry no reset; valid bits gate their contents
    always_ff @(posedge clk) begin
        if (w_do_write_hit) begin
            r_data[w_hit_way][w_index][w_offset*WORD_SIZE +: WORD_SIZE] <= r_req_wdata;
        end
        if (w_do_fill) begin
            r_data[r_victim][w_index] <= w_fill_block;
            r_tag[r_victim][w_index]  <= w_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_req_we     <= 1'b0;
            r_req_addr   <= '0;
            r_req_wdata  <= '0;
            r_victim     <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_mem_valid  <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                r_rr[s]    <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_resp_valid <= 1'b0;
                    if (cpu_req_valid) begin
                        r_req_we    <= cpu_req_we;
                        r_req_addr  <= cpu_req_addr;
                        r_req_wdata <= cpu_req_wdata;
                        r_state     <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (w_hit) begin
                        if (r_req_we) begin
                            r_dirty[w_index][w_hit_way] <= 1'b1;
                            r_resp_rdata                <= '0;
                        end else begin
                            r_resp_rdata <= w_hit_word;
                        end
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESPOND;
                    end else begin
                        r_victim    <= w_victim;
                        r_mem_valid <= 1'b1;
                        if (r_valid[w_index][w_victim] && r_dirty[w_index][w_victim]) begin
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= {r_tag[w_victim][w_index], w_index, {OFFSET_WIDTH{1'b0}}};
                            r_mem_wdata <= r_data[w_victim][w_index];
                            r_state     <= S_WB_REQ;
                        end else begin
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= {w_tag, w_index, {OFFSET_WIDTH{1'b0}}};
                            r_state    <= S_FILL_REQ;
                        end
                    end
                end
                S_WB_REQ: begin
                    if (mem_req_ready) begin
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= {w_tag, w_index, {OFFSET_WIDTH{1'b0}}};
                        r_state    <= S_FILL_REQ;
                    end
                end
                S_FILL_REQ: begin
                    if (mem_req_ready) begin
                        r_mem_valid <= 1'b0;
                        r_state     <= S_FILL_WAIT;
                    end
                end
                S_FILL_WAIT: begin
                    if (mem_resp_valid) begin
                        r_valid[w_index][r_victim] <= 1'b1;
                        r_dirty[w_index][r_victim] <= r_req_we;
                        if (WAYS > 1) r_rr[w_index] <= r_rr[w_index] + 1'b1;
                        r_resp_rdata <= r_req_we ? '0
                                      : mem_resp_rdata[w_offset*WORD_SIZE +: WORD_SIZE];
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESPOND;
                    end
                end
                S_RESPOND: begin
                    r_resp_valid <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cpu_req_ready  = (r_state == S_IDLE);
    assign cpu_resp_valid = r_resp_valid;
    assign cpu_resp_rdata = r_resp_rdata;
    assign mem_req_valid  = r_mem_valid;
    assign mem_req_we     = r_mem_we;
    assign mem_req_addr   = r_mem_addr;
    assign mem_req_wdata  = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_set_assoc_cache.sv
`default_nettype none
// ============================================================================
// Module   : tb_set_assoc_cache
// Brief    : Directed self-checking bench for the 2-way set-associative cache.
// Revision : 1.0 - initial release
// ============================================================================
module tb_set_assoc_cache;

    localparam int AW = 32;
    localparam int WS = 32;
    localparam int BS = 128;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cpu_req_valid = 1'b0;
    logic          cpu_req_ready;
    logic          cpu_req_we = 1'b0;
    logic [AW-1:0] cpu_req_addr = '0;
    logic [WS-1:0] cpu_req_wdata = '0;
    logic          cpu_resp_valid;
    logic [WS-1:0] cpu_resp_rdata;
    logic          mem_req_valid;
    logic          mem_req_ready = 1'b0;
    logic          mem_req_we;
    logic [AW-1:0] mem_req_addr;
    logic [BS-1:0] mem_req_wdata;
    logic          mem_resp_valid = 1'b0;
    logic [BS-1:0] mem_resp_rdata = '0;

    int total = 0;
    int bad = 0;
    int mem_cycles = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_req_valid) mem_cycles <= mem_cycles + 1;

    set_assoc_cache #(
        .ADDR_WIDTH(32), .WORD_SIZE(32), .WORDS_PER_BLOCK(4), .NUM_SETS(64), .WAYS(2)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
        .cpu_req_we(cpu_req_we), .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
        .cpu_resp_valid(cpu_resp_valid), .cpu_resp_rdata(cpu_resp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
    );

    task automatic check(input string tag, input logic [BS-1:0] obs, input logic [BS-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BS-1:0] blk(input logic [WS-1:0] w3, w2, w1, w0);
        return {w3, w2, w1, w0};
    endfunction

    task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [WS-1:0] wd);
        @(negedge clk);
        check("req_ready_idle", {127'd0, cpu_req_ready}, 128'd1);
        cpu_req_valid = 1'b1;
        cpu_req_we    = we;
        cpu_req_addr  = addr;
        cpu_req_wdata = wd;
        @(negedge clk);
        cpu_req_valid = 1'b0;
        cpu_req_we    = 1'b0;
        cpu_req_wdata = '0;
    endtask

    // Waits for a memory request, checks it, optionally stalls, then handshakes
    task automatic expect_mem(input string tag, input logic we, input logic [AW-1:0] addr,
                              input logic [BS-1:0] wd, input logic chk_wd, input int stall);
        int n = 0;
        while (!mem_req_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_seen"}, {127'd0, mem_req_valid}, 128'd1);
        check({tag, "_we"}, {127'd0, mem_req_we}, {127'd0, we});
        check({tag, "_addr"}, {96'd0, mem_req_addr}, {96'd0, addr});
        if (chk_wd) check({tag, "_wdata"}, mem_req_wdata, wd);
        check({tag, "_cpu_ready"}, {127'd0, cpu_req_ready}, 128'd0);
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            check({tag, "_stall_valid"}, {127'd0, mem_req_valid}, 128'd1);
            check({tag, "_stall_we"}, {127'd0, mem_req_we}, {127'd0, we});
            check({tag, "_stall_addr"}, {96'd0, mem_req_addr}, {96'd0, addr});
            check({tag, "_stall_wdata"}, mem_req_wdata, wd);
            check({tag, "_stall_cpu_ready"}, {127'd0, cpu_req_ready}, 128'd0);
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
    endtask

    task automatic mem_fill(input logic [BS-1:0] b);
        mem_resp_valid = 1'b1;
        mem_resp_rdata = b;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
    endtask

    task automatic expect_resp(input string tag, input logic [WS-1:0] rd, input int lat);
        int n = 0;
        while (!cpu_resp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, {127'd0, cpu_resp_valid}, 128'd1);
        check({tag, "_rdata"}, {96'd0, cpu_resp_rdata}, {96'd0, rd});
        if (lat >= 0) check({tag, "_latency"}, 128'(n), 128'(lat));
        @(negedge clk);
        check({tag, "_pulse"}, {127'd0, cpu_resp_valid}, 128'd0);
    endtask

    initial begin
        int m0;
        logic saw_resp;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_mem_valid", {127'd0, mem_req_valid}, 128'd0);
        check("rst_mem_we", {127'd0, mem_req_we}, 128'd0);
        check("rst_mem_addr", {96'd0, mem_req_addr}, 128'd0);
        check("rst_mem_wdata", mem_req_wdata, 128'd0);
        check("rst_resp_valid", {127'd0, cpu_resp_valid}, 128'd0);
        check("rst_resp_rdata", {96'd0, cpu_resp_rdata}, 128'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {127'd0, cpu_req_ready}, 128'd1);

        // Cold read miss into way 0
        issue(1'b0, 32'h104, 32'h0);
        expect_mem("cold_fill", 1'b0, 32'h104, '0, 1'b0, 0);
        mem_fill(blk(32'hA3, 32'hA2, 32'hA1, 32'hA0));
        expect_resp("cold_read", 32'hA0, 0);

        // Read hit, no memory traffic
        m0 = mem_cycles;
        issue(1'b0, 32'h106, 32'h0);
        expect_resp("hit_106", 32'hA2, 1);
        check("hit_106_no_mem", 128'(mem_cycles), 128'(m0));

        // Write hit then read-back
        issue(1'b1, 32'h105, 32'hDEADBEEF);
        expect_resp("whit_105", 32'h0, 1);
        m0 = mem_cycles;
        issue(1'b0, 32'h105, 32'h0);
        expect_resp("rd_105", 32'hDEADBEEF, 1);
        check("rd_105_no_mem", 128'(mem_cycles), 128'(m0));

        // Second way of set 1
        issue(1'b0, 32'h204, 32'h0);
        expect_mem("fill_204", 1'b0, 32'h204, '0, 1'b0, 0);
        mem_fill(blk(32'hB3, 32'hB2, 32'hB1, 32'hB0));
        expect_resp("rd_204", 32'hB0, 0);
        m0 = mem_cycles;
        issue(1'b0, 32'h104, 32'h0);
        expect_resp("hit_104", 32'hA0, 1);
        issue(1'b0, 32'h207, 32'h0);
        expect_resp("hit_207", 32'hB3, 1);
        check("two_way_no_mem", 128'(mem_cycles), 128'(m0));

        // Dirty eviction of way 0 with write-back backpressure
        issue(1'b0, 32'h304, 32'h0);
        expect_mem("wb_104", 1'b1, 32'h104, blk(32'hA3, 32'hA2, 32'hDEADBEEF, 32'hA0), 1'b1, 5);
        expect_mem("fill_304", 1'b0, 32'h304, '0, 1'b0, 0);
        mem_fill(blk(32'hC3, 32'hC2, 32'hC1, 32'hC0));
        expect_resp("rd_304", 32'hC0, 0);

        // Way 1 survived; round-robin now points at way 1 (clean, no write-back)
        m0 = mem_cycles;
        issue(1'b0, 32'h205, 32'h0);
        expect_resp("hit_205", 32'hB1, 1);
        check("hit_205_no_mem", 128'(mem_cycles), 128'(m0));
        issue(1'b1, 32'h406, 32'h12345678);
        expect_mem("fill_404", 1'b0, 32'h404, '0, 1'b0, 0);
        mem_fill(blk(32'hD3, 32'hD2, 32'hD1, 32'hD0));
        expect_resp("wmiss_406", 32'h0, 0);
        m0 = mem_cycles;
        issue(1'b0, 32'h406, 32'h0);
        expect_resp("rd_406", 32'h12345678, 1);
        issue(1'b0, 32'h307, 32'h0);
        expect_resp("hit_307", 32'hC3, 1);
        check("rr_no_mem", 128'(mem_cycles), 128'(m0));

        // Reset while waiting for fill data
        issue(1'b0, 32'h504, 32'h0);
        expect_mem("fill_504", 1'b0, 32'h504, '0, 1'b0, 0);
        check("fill_wait_not_ready", {127'd0, cpu_req_ready}, 128'd0);
        rst = 1'b1;
        #1;
        check("midrst_mem_valid", {127'd0, mem_req_valid}, 128'd0);
        check("midrst_ready", {127'd0, cpu_req_ready}, 128'd1);
        @(negedge clk);
        rst = 1'b0;
        saw_resp = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = blk(32'hE3, 32'hE2, 32'hE1, 32'hE0);
        @(negedge clk);
        mem_resp_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (cpu_resp_valid) saw_resp = 1'b1;
            @(negedge clk);
        end
        check("midrst_no_resp", {127'd0, saw_resp}, 128'd0);

        // All lines invalid again: 0x104 misses
        issue(1'b0, 32'h104, 32'h0);
        expect_mem("refill_104", 1'b0, 32'h104, '0, 1'b0, 0);
        mem_fill(blk(32'hF3, 32'hF2, 32'hF1, 32'hF0));
        expect_resp("reread_104", 32'hF0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
